// File: rtl/adder_seq_pkg.sv
// Shared types for the adder sequencer: opcodes, FSM states and the
// datapath control word with its inactive value.
package adder_seq_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LDA  = 3'b001,
        OP_LDB  = 3'b010,
        OP_ADD  = 3'b011,
        OP_SUB  = 3'b100,
        OP_OUT  = 3'b101,
        OP_ILL6 = 3'b110,
        OP_ILL7 = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC1  = 3'd2,
        ST_EXEC2  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Strobes towards the datapath; nla/nlb are active-low load enables.
    typedef struct packed {
        logic nla;
        logic nlb;
        logic ea;
        logic eu;
        logic sub;
        logic out_sel;
    } ctrl_t;

    localparam ctrl_t CTRL_INACTIVE = '{
        nla:     1'b1,
        nlb:     1'b1,
        ea:      1'b0,
        eu:      1'b0,
        sub:     1'b0,
        out_sel: 1'b0
    };

    function automatic logic is_legal(input op_e op);
        return (op != OP_ILL6) && (op != OP_ILL7);
    endfunction

    // ADD and SUB are the only ops that need the second execute cycle.
    function automatic logic is_arith(input op_e op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/adder_seq_decode.sv
// Purely combinational map from (FSM state, latched opcode) to the
// datapath control word. Any state/opcode pair without a specific
// action yields the inactive word.
module adder_seq_decode
    import adder_seq_pkg::*;
(
    input  state_e i_state,
    input  op_e    i_op,
    output ctrl_t  o_ctrl
);

    // Build the control word for the current state and opcode.
    always_comb begin
        // NOTE: default first so every path assigns o_ctrl; no latch can be inferred.
        o_ctrl = CTRL_INACTIVE;
        case (i_state)
            ST_EXEC1: begin
                case (i_op)
                    OP_LDA: o_ctrl.nla = 1'b0;
                    OP_LDB: o_ctrl.nlb = 1'b0;
                    OP_ADD: o_ctrl.eu  = 1'b1;
                    OP_SUB: begin
                        o_ctrl.eu  = 1'b1;
                        o_ctrl.sub = 1'b1;
                    end
                    OP_OUT: begin
                        o_ctrl.ea      = 1'b1;
                        o_ctrl.out_sel = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_EXEC2: begin
                // Write the ALU result back into A while holding the ALU mode.
                if (is_arith(i_op)) begin
                    o_ctrl.eu  = 1'b1;
                    o_ctrl.sub = (i_op == OP_SUB);
                    o_ctrl.nla = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/adder_sequencer.sv
// Opcode sequencer for a small A/B accumulator datapath. Accepts one
// opcode at a time in IDLE, walks DECODE -> EXEC1 [-> EXEC2] -> DONE,
// captures ALU flags for ADD/SUB and counts completed operations.
module adder_sequencer
    import adder_seq_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [2:0]       op_code,
    output logic             op_ready,
    input  logic             cf_in,
    input  logic             zf_in,
    output logic             nla,
    output logic             nlb,
    output logic             ea,
    output logic             eu,
    output logic             sub,
    output logic             out_sel,
    output logic             done,
    output logic             err,
    output logic             cf_q,
    output logic             zf_q,
    output logic [CNT_W-1:0] op_count
);

    state_e             r_state;
    state_e             w_next_state;
    op_e                r_op;
    logic               r_cf;
    logic               r_zf;
    logic [CNT_W-1:0]   r_count;
    logic               w_accept;
    ctrl_t              w_ctrl;

    assign w_accept = (r_state == ST_IDLE) && op_valid;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: every register here resets synchronously inside the clocked block; there is no storage array that would need to skip reset.
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: non-blocking assignment so all registers update together from pre-edge values.
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (op_valid) w_next_state = ST_DECODE;
            ST_DECODE: w_next_state = is_legal(r_op) ? ST_EXEC1 : ST_DONE;
            ST_EXEC1:  w_next_state = is_arith(r_op) ? ST_EXEC2 : ST_DONE;
            ST_EXEC2:  w_next_state = ST_DONE;
            ST_DONE:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Handshake and completion outputs.
    always_comb begin
        op_ready = (r_state == ST_IDLE);
        done     = (r_state == ST_DONE);
        err      = (r_state == ST_DONE) && !is_legal(r_op);
    end

    // Hold the accepted opcode for the rest of the operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op <= OP_NOP;
        end else if (w_accept) begin
            r_op <= op_e'(op_code);
        end
    end

    // Flags are captured only at the end of EXEC2, which only ADD/SUB reach.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cf <= 1'b0;
            r_zf <= 1'b0;
        end else if (r_state == ST_EXEC2) begin
            r_cf <= cf_in;
            r_zf <= zf_in;
        end
    end

    // Completed-operation counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (r_state == ST_DONE) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    adder_seq_decode u_decode (
        .i_state (r_state),
        .i_op    (r_op),
        .o_ctrl  (w_ctrl)
    );

    assign nla      = w_ctrl.nla;
    assign nlb      = w_ctrl.nlb;
    assign ea       = w_ctrl.ea;
    assign eu       = w_ctrl.eu;
    assign sub      = w_ctrl.sub;
    assign out_sel  = w_ctrl.out_sel;
    assign cf_q     = r_cf;
    assign zf_q     = r_zf;
    assign op_count = r_count;

endmodule

// File: tb/tb_adder_sequencer.sv
// Scoreboard bench for adder_sequencer. The driver predicts when each
// opcode is accepted and queues it; the monitor expects, cycle by cycle,
// the control word, done/err and flags derived from opcode timing rules.
module tb_adder_sequencer;

    localparam int         CNT_W  = 2;
    localparam logic [5:0] W_IDLE = 6'b110000; // {nla,nlb,ea,eu,sub,out_sel}

    logic             clk = 1'b0;
    logic             rst;
    logic             op_valid;
    logic [2:0]       op_code;
    logic             op_ready;
    logic             cf_in;
    logic             zf_in;
    logic             nla, nlb, ea, eu, sub, out_sel;
    logic             done, err, cf_q, zf_q;
    logic [CNT_W-1:0] op_count;

    adder_sequencer #(.CNT_W(CNT_W)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op_code  (op_code),
        .op_ready (op_ready),
        .cf_in    (cf_in),
        .zf_in    (zf_in),
        .nla      (nla),
        .nlb      (nlb),
        .ea       (ea),
        .eu       (eu),
        .sub      (sub),
        .out_sel  (out_sel),
        .done     (done),
        .err      (err),
        .cf_q     (cf_q),
        .zf_q     (zf_q),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        int         acc;  // cycle in which the opcode was accepted
        int         cnt;  // op_count expected after this op completes
    } txn_t;

    txn_t q[$];
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   cyc       = 0;
    int   model_cnt = 0;
    int   free_cyc  = 0;
    int   flag_mode = 0;
    bit   mon_en    = 1'b0;
    bit   rst_hit   = 1'b0;
    logic exp_cf    = 1'b0;
    logic exp_zf    = 1'b0;
    bit   pend_v    = 1'b0;
    int   pend_cnt  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycles from accept to done.
    function automatic int lat_of(input logic [2:0] op);
        if (op >= 3'd6) return 2;
        if (op == 3'd3 || op == 3'd4) return 4;
        return 3;
    endfunction

    // Control word expected 'rel' cycles after the accept cycle.
    function automatic logic [5:0] word_of(input logic [2:0] op, input int rel);
        logic [5:0] w;
        w = W_IDLE;
        if (rel == 2) begin
            case (op)
                3'd1:    w = 6'b010000;
                3'd2:    w = 6'b100000;
                3'd3:    w = 6'b110100;
                3'd4:    w = 6'b110110;
                3'd5:    w = 6'b111001;
                default: w = W_IDLE;
            endcase
        end else if (rel == 3 && (op == 3'd3 || op == 3'd4)) begin
            w = {1'b0, 1'b1, 1'b0, 1'b1, (op == 3'd4), 1'b0};
        end
        return w;
    endfunction

    // Datapath flag inputs change mid-cycle, away from both clock edges.
    initial begin
        cf_in = 1'b0;
        zf_in = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (flag_mode == 1) begin
                cf_in = 1'b1;
                zf_in = 1'b1;
            end else begin
                cf_in = 1'($urandom_range(0, 1));
                zf_in = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: compares every cycle against the head of the scoreboard.
    initial begin
        txn_t       t;
        int         rel;
        logic [5:0] w_exp;
        logic [5:0] w_act;
        logic       e_done;
        logic       e_err;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (rst_hit) begin
                    q.delete();
                    exp_cf  = 1'b0;
                    exp_zf  = 1'b0;
                    pend_v  = 1'b0;
                    rst_hit = 1'b0;
                end
                if (pend_v) begin
                    check("op_count", int'(op_count), pend_cnt);
                    pend_v = 1'b0;
                end
                w_act = {nla, nlb, ea, eu, sub, out_sel};
                check("ea_eu_exclusive", int'(ea & eu), 0);
                check("nla_nlb_exclusive", int'(!nla && !nlb), 0);
                w_exp  = W_IDLE;
                e_done = 1'b0;
                e_err  = 1'b0;
                if (q.size() > 0) begin
                    t     = q[0];
                    rel   = cyc - t.acc;
                    w_exp = word_of(t.op, rel);
                    if (rel == 3 && (t.op == 3'd3 || t.op == 3'd4)) begin
                        exp_cf = cf_in;
                        exp_zf = zf_in;
                    end
                    if (rel >= lat_of(t.op)) begin
                        e_done = 1'b1;
                        e_err  = (t.op >= 3'd6);
                        check("cf_q", int'(cf_q), int'(exp_cf));
                        check("zf_q", int'(zf_q), int'(exp_zf));
                        pend_v   = 1'b1;
                        pend_cnt = t.cnt;
                        void'(q.pop_front());
                    end
                end
                check("ctrl_word", int'(w_act), int'(w_exp));
                check("done", int'(done), int'(e_done));
                check("err", int'(err), int'(e_err));
                if (rst) rst_hit = 1'b1;
            end
        end
    end

    // Offer one opcode after 'gap' idle cycles (gap 0 keeps op_valid high).
    task automatic issue(input logic [2:0] op, input int gap);
        int vcyc;
        int exp_acc;
        int acc;
        bit got;
        if (gap > 0) begin
            op_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        op_valid = 1'b1;
        op_code  = op;
        vcyc     = cyc;
        exp_acc  = (vcyc > free_cyc) ? vcyc : free_cyc;
        got      = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (op_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: opcode %0d not accepted within 40 cycles", op);
            op_valid = 1'b0;
            return;
        end
        acc = cyc;
        check("accept_cycle", acc, exp_acc);
        @(posedge clk);
        #1;
        model_cnt = (model_cnt + 1) % (1 << CNT_W);
        q.push_back('{op: op, acc: acc, cnt: model_cnt});
        free_cyc = acc + lat_of(op) + 1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        op_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        op_valid = 1'b0;
        op_code  = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_op_ready", int'(op_ready), 1);
        check("reset_ctrl_word", int'({nla, nlb, ea, eu, sub, out_sel}), int'(W_IDLE));
        check("reset_done", int'(done), 0);
        check("reset_err", int'(err), 0);
        check("reset_cf_q", int'(cf_q), 0);
        check("reset_zf_q", int'(zf_q), 0);
        check("reset_op_count", int'(op_count), 0);
        rst       = 1'b0;
        model_cnt = 0;
        free_cyc  = cyc;
        mon_en    = 1'b1;
        idle(2);

        // Single LDA, then SUB with both ALU flags set, then an illegal opcode.
        issue(3'd1, 0);
        idle(6);
        flag_mode = 1;
        issue(3'd4, 0);
        idle(7);
        flag_mode = 0;
        issue(3'd7, 0);
        idle(5);

        // op_valid held high across an OUT, OUT, ADD stream.
        issue(3'd5, 0);
        issue(3'd5, 0);
        issue(3'd3, 0);
        idle(8);

        // Five back-to-back NOPs wrap the 2-bit counter.
        for (int i = 0; i < 5; i++) issue(3'd0, 0);
        idle(6);

        // Reset during EXEC1 of an ADD aborts it.
        issue(3'd3, 0);
        op_valid = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #3 rst = 1'b0;
        model_cnt = 0;
        free_cyc  = cyc;
        @(negedge clk);
        check("abort_op_ready", int'(op_ready), 1);
        check("abort_op_count", int'(op_count), 0);
        check("abort_done", int'(done), 0);
        check("abort_ctrl_word", int'({nla, nlb, ea, eu, sub, out_sel}), int'(W_IDLE));
        idle(4);

        // Random opcodes and gaps.
        for (int i = 0; i < 150; i++) begin
            issue(3'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
        end
        idle(12);
        check("queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
